// File: rtl/seg7_scan_ascii.sv
// ---------------------------------------------------------------------------
// seg7_scan_ascii
//   Snoops a multiplexed 7-segment display bus, debounces each digit strobe,
//   collects one full scan frame, and streams it out as ASCII over
//   valid/ready. The leftmost digit goes first. An optional terminator byte
//   follows each frame.
//
// Ports
//   clk, rst_n  : clock, asynchronous active-low reset
//   seg_in      : segments {a,b,c,d,e,f,g}, a = MSB (polarity set by parameter)
//   dig_sel     : one strobe per digit, bit NUM_DIGITS-1 = leftmost digit
//   alpha_mode  : 1 = ambiguous glyphs decode as 'O'/'S', 0 = as '0'/'5'
//   out_data    : ASCII byte
//   out_valid   : out_data is valid
//   out_ready   : sink accepts the byte on a clock edge with out_valid high
//   out_last    : marks the final byte of a frame
//   overrun     : one-cycle pulse when a completed frame is dropped
//   drop_cnt    : saturating count of dropped frames
//   busy        : emitter is streaming a frame
// ---------------------------------------------------------------------------
module seg7_scan_ascii #(
    parameter int         NUM_DIGITS     = 4,
    parameter bit         SEG_ACTIVE_LOW = 1'b1,
    parameter bit         DIG_ACTIVE_LOW = 1'b0,
    parameter int         STABLE_CYC     = 3,
    parameter bit         CHANGE_ONLY    = 1'b1,
    parameter bit         TERM_EN        = 1'b1,
    parameter logic [7:0] TERM_CHAR      = 8'h0A,
    parameter logic [7:0] UNKNOWN_CHAR   = 8'h3F
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg_in,
    input  logic [NUM_DIGITS-1:0] dig_sel,
    input  logic                  alpha_mode,
    output logic [7:0]            out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overrun,
    output logic [7:0]            drop_cnt,
    output logic                  busy
);

    localparam int CW = (STABLE_CYC < 2) ? 1 : $clog2(STABLE_CYC + 1);
    localparam int IW = (NUM_DIGITS < 2) ? 1 : $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {IDLE, SEND, TERM} state_t;

    function automatic logic [7:0] decode(input logic [6:0] s, input logic alpha);
        case (s)
            7'b1111110: decode = alpha ? "O" : "0";
            7'b0110000: decode = "1";
            7'b1101101: decode = "2";
            7'b1111001: decode = "3";
            7'b0110011: decode = "4";
            7'b1011011: decode = alpha ? "S" : "5";
            7'b1011111: decode = "6";
            7'b1110000: decode = "7";
            7'b1111111: decode = "8";
            7'b1111011: decode = "9";
            7'b1110111: decode = "A";
            7'b0011111: decode = "b";
            7'b1001110: decode = "C";
            7'b0111101: decode = "d";
            7'b1001111: decode = "E";
            7'b1000111: decode = "F";
            7'b0110111: decode = "H";
            7'b0001110: decode = "L";
            7'b1100111: decode = "P";
            7'b0111110: decode = "U";
            7'b0000001: decode = "-";
            7'b0000000: decode = " ";
            default:    decode = UNKNOWN_CHAR;
        endcase
    endfunction

    // ---------------- capture side ----------------
    logic [6:0]                  seg_n, prev_seg;
    logic [NUM_DIGITS-1:0]       dig_n, prev_dig;
    logic [CW-1:0]               cnt, cnt_next;
    logic [NUM_DIGITS-1:0]       mask, mask_next;
    logic [NUM_DIGITS-1:0][6:0]  dig_reg;
    logic [IW-1:0]               dig_idx;
    logic                        strobe_ok, pair_changed, capture, frame_full;

    assign seg_n        = SEG_ACTIVE_LOW ? ~seg_in : seg_in;
    assign dig_n        = DIG_ACTIVE_LOW ? ~dig_sel : dig_sel;
    assign strobe_ok    = $onehot(dig_n);
    assign pair_changed = {dig_n, seg_n} != {prev_dig, prev_seg};
    assign frame_full   = &mask;

    // NOTE: every variable driven here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        dig_idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (dig_n[i]) dig_idx = IW'(i);
        end

        if (!strobe_ok)                   cnt_next = '0;
        else if (pair_changed)            cnt_next = CW'(1);
        else if (cnt == CW'(STABLE_CYC))  cnt_next = cnt;
        else                              cnt_next = cnt + CW'(1);

        // Capture only on the edge that reaches the threshold; a new dwell
        // that reaches it immediately (STABLE_CYC == 1) also counts.
        capture = strobe_ok && (cnt_next == CW'(STABLE_CYC)) &&
                  ((cnt != CW'(STABLE_CYC)) || pair_changed);

        // A capture on the frame-hand-off edge belongs to the next frame.
        mask_next = frame_full ? '0 : mask;
        if (capture) mask_next[dig_idx] = 1'b1;
    end

    // NOTE: the digit store is a handful of flops, so it is reset with the
    // rest of the state; a real RAM would be left unreset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_seg <= '0;
            prev_dig <= '0;
            cnt      <= '0;
            mask     <= '0;
            dig_reg  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            prev_seg <= seg_n;
            prev_dig <= dig_n;
            cnt      <= cnt_next;
            mask     <= mask_next;
            if (capture) dig_reg[dig_idx] <= seg_n;
        end
    end

    // ---------------- emitter side ----------------
    state_t                      state, state_next;
    logic [IW-1:0]               idx, idx_next;
    // The frame being sent is also the last-sent reference: both are only
    // ever written when a frame is accepted for sending.
    logic [NUM_DIGITS-1:0][6:0]  sent_digits;
    logic                        sent_alpha;
    logic                        first_frame;
    logic                        accept, load_frame, drop_frame, same_frame;

    assign accept     = out_valid && out_ready;
    assign same_frame = ({alpha_mode, dig_reg} == {sent_alpha, sent_digits});

    always_comb begin
        state_next = state;
        idx_next   = idx;
        load_frame = 1'b0;
        drop_frame = 1'b0;
        out_valid  = 1'b0;
        out_data   = 8'h00;
        out_last   = 1'b0;
        case (state)
            IDLE: begin
                if (frame_full && !(CHANGE_ONLY && !first_frame && same_frame)) begin
                    load_frame = 1'b1;
                    state_next = SEND;
                    idx_next   = IW'(NUM_DIGITS - 1);
                end
            end
            SEND: begin
                drop_frame = frame_full;
                out_valid  = 1'b1;
                out_data   = decode(sent_digits[idx], sent_alpha);
                out_last   = !TERM_EN && (idx == '0);
                if (accept) begin
                    if (idx == '0) state_next = TERM_EN ? TERM : IDLE;
                    else           idx_next   = idx - IW'(1);
                end
            end
            TERM: begin
                drop_frame = frame_full;
                out_valid  = 1'b1;
                out_data   = TERM_CHAR;
                out_last   = 1'b1;
                if (accept) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            sent_digits <= '0;
            sent_alpha  <= 1'b0;
            first_frame <= 1'b1;
            overrun     <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            overrun <= drop_frame;
            if (drop_frame && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            if (load_frame) begin
                sent_digits <= dig_reg;
                sent_alpha  <= alpha_mode;
                first_frame <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_ascii.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ascii
//   Directed bench for seg7_scan_ascii with default parameters (4 digits,
//   active-low segments, active-high strobes, STABLE_CYC = 3).
// ---------------------------------------------------------------------------
module tb_seg7_scan_ascii;

    // Active-high glyph patterns {a..g}; the bus is active-low so they are
    // inverted when driven.
    localparam logic [6:0] G_H   = 7'b0110111;
    localparam logic [6:0] G_E   = 7'b1001111;
    localparam logic [6:0] G_L   = 7'b0001110;
    localparam logic [6:0] G_0   = 7'b1111110;
    localparam logic [6:0] G_1   = 7'b0110000;
    localparam logic [6:0] G_2   = 7'b1101101;
    localparam logic [6:0] G_3   = 7'b1111001;
    localparam logic [6:0] G_4   = 7'b0110011;
    localparam logic [6:0] G_5   = 7'b1011011;
    localparam logic [6:0] G_P   = 7'b1100111;
    localparam logic [6:0] G_A   = 7'b1110111;
    localparam logic [6:0] G_D   = 7'b0111101;
    localparam logic [6:0] G_C   = 7'b1001110;
    localparam logic [6:0] G_DSH = 7'b0000001;
    localparam logic [6:0] G_OFF = 7'b0000000;
    localparam logic [6:0] G_BAD = 7'b1100011;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] dig_sel;
    logic       alpha_mode;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       overrun;
    logic [7:0] drop_cnt;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;
    int ov_seen  = 0;
    logic [8:0] got[$];

    seg7_scan_ascii dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .dig_sel    (dig_sel),
        .alpha_mode (alpha_mode),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .overrun    (overrun),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs only change 1 ns after a rising edge, so a byte seen valid and
    // ready at the falling edge is the one accepted at the next rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid && out_ready) got.push_back({out_last, out_data});
            if (overrun) ov_seen++;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scan_frame(input logic [3:0][6:0] p, input int dwell);
        for (int i = 3; i >= 0; i--) begin
            dig_sel = 4'b0001 << i;
            seg_in  = ~p[i];
            repeat (dwell) tick();
        end
        dig_sel = 4'b0000;
    endtask

    task automatic expect_frame(input string tag, input string s);
        int n;
        n = s.len() + 1;
        for (int t = 0; t < 200 && got.size() < n; t++) tick();
        check({tag, " count"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            if (i < n - 1) check($sformatf("%s byte%0d", tag, i), got[i], {1'b0, s[i]});
            else           check($sformatf("%s term", tag), got[i], {1'b1, 8'h0A});
        end
        got.delete();
    endtask

    initial begin
        rst_n      = 1'b0;
        seg_in     = 7'h7F;
        dig_sel    = 4'b0000;
        alpha_mode = 1'b1;
        out_ready  = 1'b1;
        repeat (3) tick();

        // Reset state
        check("rst out_valid", out_valid, 0);
        check("rst out_data",  out_data,  0);
        check("rst out_last",  out_last,  0);
        check("rst overrun",   overrun,   0);
        check("rst drop_cnt",  drop_cnt,  0);
        check("rst busy",      busy,      0);
        rst_n = 1'b1;
        tick();

        // T1: HELO with alpha decoding, terminator carries out_last
        scan_frame({G_H, G_E, G_L, G_0}, 5);
        expect_frame("t1", "HELO");
        check("t1 idle busy", busy, 0);

        // T2: identical frame is suppressed; alpha change makes it new
        scan_frame({G_H, G_E, G_L, G_0}, 5);
        repeat (30) tick();
        check("t2 suppressed", got.size(), 0);
        alpha_mode = 1'b0;
        scan_frame({G_H, G_E, G_L, G_0}, 5);
        expect_frame("t2", "HEL0");

        // T3: short dwell and multi-hot strobe must not capture
        dig_sel = 4'b1000; seg_in = ~G_P; repeat (5) tick();
        dig_sel = 4'b0100; seg_in = ~G_A; repeat (5) tick();
        dig_sel = 4'b0010; seg_in = ~G_5; repeat (5) tick();
        dig_sel = 4'b0001; seg_in = ~G_D; repeat (2) tick();
        dig_sel = 4'b0011; repeat (10) tick();
        dig_sel = 4'b0000; repeat (20) tick();
        check("t3 no capture", got.size(), 0);
        check("t3 no busy", busy, 0);
        dig_sel = 4'b0001; seg_in = ~G_D; repeat (5) tick();
        dig_sel = 4'b0000;
        expect_frame("t3", "PA5d");

        // T4: stall mid-frame, then overrun and saturation
        out_ready = 1'b0;
        scan_frame({G_1, G_2, G_3, G_4}, 5);
        for (int t = 0; t < 20 && !out_valid; t++) tick();
        check("t4 valid", out_valid, 1);
        check("t4 first byte", out_data, "1");
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t4 stall data", {out_valid, out_last, out_data}, {2'b10, 8'h32});
            tick();
        end
        scan_frame({G_5, G_5, G_5, G_5}, 5);
        repeat (3) tick();
        check("t4 overrun pulse", ov_seen, 1);
        check("t4 drop_cnt 1", drop_cnt, 1);
        for (int f = 0; f < 299; f++) scan_frame({G_A, G_A, G_A, G_A}, 3);
        repeat (3) tick();
        check("t4 drop_cnt sat", drop_cnt, 255);
        check("t4 overrun count", ov_seen, 300);
        check("t4 held data", {out_valid, out_data}, {1'b1, 8'h32});
        check("t4 accepted count", got.size(), 1);
        if (got.size() > 0) check("t4 accepted byte", got[0], {1'b0, 8'h31});
        got.delete();

        // T5: asynchronous reset while stalled at idx=2
        #3;
        rst_n = 1'b0;
        #1;
        check("t5 valid drop", out_valid, 0);
        check("t5 busy", busy, 0);
        check("t5 drop_cnt", drop_cnt, 0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        scan_frame({G_1, G_2, G_3, G_4}, 5);
        expect_frame("t5", "1234");

        // T6: unmapped pattern and blank digit
        scan_frame({G_BAD, G_OFF, G_DSH, G_C}, 5);
        expect_frame("t6", "? -C");

        repeat (20) tick();
        check("end no stray bytes", got.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
